// File: rtl/writeback_unit_pkg.sv
// Shared types and defaults for the write-back stage.
// Result source selector used by the write-port mux.
package writeback_unit_pkg;
   localparam int RAWIDTH_DEF = 5;
   localparam int DWIDTH_DEF  = 32;

   typedef enum logic [1:0] {
      WB_IDLE,
      WB_ALU,
      WB_EXT
   } wb_src_e;
endpackage

// File: rtl/writeback_unit_wb_fifo.sv
// Small synchronous FIFO for long-latency results.
// A push is refused whenever full, even if a pop happens in the same cycle.
module wb_fifo #(
   parameter int W     = 37,
   parameter int DEPTH = 2,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic [W-1:0]  wdata,
   input  logic          pop,
   output logic [W-1:0]  rdata,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   // Power-of-two depth lets the pointers wrap by overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/writeback_unit.sv
// Write-back stage: merges ALU and long-latency results into the
// single register file write port, with a starvation guard on the queue.
module writeback_unit
   import writeback_unit_pkg::*;
#(
   parameter int RAWIDTH    = RAWIDTH_DEF,
   parameter int DWIDTH     = DWIDTH_DEF,
   parameter int QDEPTH     = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      alu_valid,
   input  logic [RAWIDTH-1:0]        alu_rd,
   input  logic [DWIDTH-1:0]         alu_data,
   output logic                      alu_stall,
   input  logic                      ext_valid,
   output logic                      ext_ready,
   input  logic [RAWIDTH-1:0]        ext_rd,
   input  logic [DWIDTH-1:0]         ext_data,
   output logic                      RegWEn,
   output logic [RAWIDTH-1:0]        AddrD,
   output logic [DWIDTH-1:0]         DataD,
   output logic [$clog2(QDEPTH):0]   q_count
);
   localparam int EW = RAWIDTH + DWIDTH;
   localparam int CW = $clog2(QDEPTH) + 1;
   localparam int SW = $clog2(STARVE_MAX + 1);

   logic [EW-1:0]      head;
   logic               full;
   logic               empty;
   logic               push;
   logic               pop;
   logic [SW-1:0]      starve_cnt;
   wb_src_e            src;
   logic [RAWIDTH-1:0] sel_rd;
   logic [DWIDTH-1:0]  sel_data;

   assign ext_ready = !full;
   assign push      = ext_valid && ext_ready;
   assign alu_stall = (starve_cnt == SW'(STARVE_MAX));
   assign pop       = (src == WB_EXT);

   wb_fifo #(
      .W     (EW),
      .DEPTH (QDEPTH),
      .CW    (CW)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .wdata ({ext_rd, ext_data}),
      .pop   (pop),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .count (q_count)
   );

   // Forced pop outranks the ALU; otherwise the ALU has priority.
   always_comb begin
      src      = WB_IDLE;
      sel_rd   = alu_rd;
      sel_data = alu_data;
      if (alu_stall && !empty) begin
         src      = WB_EXT;
         sel_rd   = head[EW-1:DWIDTH];
         sel_data = head[DWIDTH-1:0];
      end else if (alu_valid) begin
         src = WB_ALU;
      end else if (!empty) begin
         src      = WB_EXT;
         sel_rd   = head[EW-1:DWIDTH];
         sel_data = head[DWIDTH-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt <= '0;
      end else if (empty || pop) begin
         starve_cnt <= '0;
      end else if (!alu_stall) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end

   // x0 writes are consumed but never enable the port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         RegWEn <= 1'b0;
         AddrD  <= '0;
         DataD  <= '0;
      end else if (src == WB_IDLE) begin
         RegWEn <= 1'b0;
      end else begin
         RegWEn <= (sel_rd != '0);
         AddrD  <= sel_rd;
         DataD  <= sel_data;
      end
   end
endmodule

// File: tb/tb_writeback_unit.sv
// Randomised and directed bench for writeback_unit.
// Expected behaviour comes from a queue-based model of the write-back rules.
module tb_writeback_unit;
   localparam int RAWIDTH    = 5;
   localparam int DWIDTH     = 32;
   localparam int QDEPTH     = 2;
   localparam int STARVE_MAX = 4;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               alu_valid = 1'b0;
   logic [RAWIDTH-1:0] alu_rd = '0;
   logic [DWIDTH-1:0]  alu_data = '0;
   logic               alu_stall;
   logic               ext_valid = 1'b0;
   logic               ext_ready;
   logic [RAWIDTH-1:0] ext_rd = '0;
   logic [DWIDTH-1:0]  ext_data = '0;
   logic               RegWEn;
   logic [RAWIDTH-1:0] AddrD;
   logic [DWIDTH-1:0]  DataD;
   logic [$clog2(QDEPTH):0] q_count;

   int n_checks = 0;
   int n_errors = 0;

   logic [RAWIDTH+DWIDTH-1:0] mq [$];
   int                        m_starve;
   logic                      m_wen;
   logic [RAWIDTH-1:0]        m_addr;
   logic [DWIDTH-1:0]         m_data;

   always #5 clk = ~clk;

   writeback_unit #(
      .RAWIDTH    (RAWIDTH),
      .DWIDTH     (DWIDTH),
      .QDEPTH     (QDEPTH),
      .STARVE_MAX (STARVE_MAX)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .alu_valid (alu_valid),
      .alu_rd    (alu_rd),
      .alu_data  (alu_data),
      .alu_stall (alu_stall),
      .ext_valid (ext_valid),
      .ext_ready (ext_ready),
      .ext_rd    (ext_rd),
      .ext_data  (ext_data),
      .RegWEn    (RegWEn),
      .AddrD     (AddrD),
      .DataD     (DataD),
      .q_count   (q_count)
   );

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_starve = 0;
      m_wen    = 1'b0;
      m_addr   = '0;
      m_data   = '0;
   endtask

   task automatic check_all();
      check("RegWEn", 32'(RegWEn), 32'(m_wen));
      if (m_wen) begin
         check("AddrD", 32'(AddrD), 32'(m_addr));
         check("DataD", DataD, m_data);
      end
      check("q_count", 32'(q_count), 32'(mq.size()));
      check("ext_ready", 32'(ext_ready),
            32'(mq.size() < QDEPTH));
      check("alu_stall", 32'(alu_stall),
            32'(m_starve == STARVE_MAX));
   endtask

   // One cycle: drive after the negedge, model it, check at the next negedge.
   task automatic step(input logic av,
                       input logic [RAWIDTH-1:0] ard,
                       input logic [DWIDTH-1:0] ad,
                       input logic ev,
                       input logic [RAWIDTH-1:0] erd,
                       input logic [DWIDTH-1:0] ed);
      logic stall;
      logic was_empty;
      logic accept;
      logic popped;
      logic [RAWIDTH+DWIDTH-1:0] e;
      stall     = (m_starve == STARVE_MAX);
      alu_valid = av && !stall;
      alu_rd    = ard;
      alu_data  = ad;
      ext_valid = ev;
      ext_rd    = erd;
      ext_data  = ed;
      was_empty = (mq.size() == 0);
      accept    = ev && (mq.size() < QDEPTH);
      popped    = 1'b0;
      if (!was_empty && (stall || !alu_valid)) begin
         e      = mq.pop_front();
         popped = 1'b1;
         m_addr = e[RAWIDTH+DWIDTH-1:DWIDTH];
         m_data = e[DWIDTH-1:0];
         m_wen  = (m_addr != 0);
      end else if (alu_valid) begin
         m_addr = ard;
         m_data = ad;
         m_wen  = (ard != 0);
      end else begin
         m_wen = 1'b0;
      end
      m_starve = (was_empty || popped) ? 0 : m_starve + 1;
      if (accept) mq.push_back({erd, ed});
      @(posedge clk);
      @(negedge clk);
      check_all();
   endtask

   task automatic idle();
      step(1'b0, '0, '0, 1'b0, '0, '0);
   endtask

   initial begin
      model_reset();
      repeat (3) @(negedge clk);
      check("rst_RegWEn", 32'(RegWEn), 32'd0);
      check("rst_q_count", 32'(q_count), 32'd0);
      check("rst_ext_ready", 32'(ext_ready), 32'd1);
      rst_n = 1'b1;
      idle();

      // ALU only
      step(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, '0, '0);
      check("alu_addr", 32'(AddrD), 32'd5);
      check("alu_data", DataD, 32'hDEAD_BEEF);
      idle();
      check("alu_idle", 32'(RegWEn), 32'd0);

      // Priority: ALU first, queued ext next
      step(1'b1, 5'd3, 32'h22, 1'b1, 5'd7, 32'h11);
      check("prio_first", 32'(AddrD), 32'd3);
      idle();
      check("prio_second", 32'(AddrD), 32'd7);
      idle();

      // Fill while the ALU hogs the port; starvation must force a pop
      step(1'b1, 5'd1, 32'hA1, 1'b1, 5'd9, 32'h91);
      step(1'b1, 5'd2, 32'hA2, 1'b1, 5'd10, 32'h92);
      check("full_ready", 32'(ext_ready), 32'd0);
      step(1'b1, 5'd4, 32'hA3, 1'b1, 5'd11, 32'h93);
      for (int i = 0; i < 6; i++)
         step(1'b1, 5'(12 + i), 32'hB0 + i, 1'b0, '0, '0);
      repeat (3) idle();

      // x0 destination is popped without a write
      step(1'b0, '0, '0, 1'b1, 5'd0, 32'hFFFF);
      idle();
      check("x0_wen", 32'(RegWEn), 32'd0);
      idle();

      // Streaming through the queue
      for (int i = 0; i < 8; i++)
         step(1'b0, '0, '0, 1'b1, 5'(i + 1), 32'h100 + i);
      repeat (2) idle();

      // Reset mid-stream with a full queue
      step(1'b1, 5'd6, 32'h1, 1'b1, 5'd8, 32'h2);
      step(1'b1, 5'd6, 32'h3, 1'b1, 5'd8, 32'h4);
      check("pre_rst_count", 32'(q_count), 32'd2);
      rst_n = 1'b0;
      #1;
      model_reset();
      check("mid_rst_RegWEn", 32'(RegWEn), 32'd0);
      check("mid_rst_AddrD", 32'(AddrD), 32'd0);
      check("mid_rst_DataD", DataD, 32'd0);
      check("mid_rst_q_count", 32'(q_count), 32'd0);
      check("mid_rst_ready", 32'(ext_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      alu_valid = 1'b0;
      ext_valid = 1'b0;

      // Random traffic with busy and quiet ALU phases
      for (int i = 0; i < 400; i++) begin
         int pa;
         pa = ((i / 50) % 2 == 0) ? 90 : 40;
         step(($urandom_range(99) < pa),
              5'($urandom_range(31)),
              32'($urandom),
              ($urandom_range(99) < 50),
              5'($urandom_range(31)),
              32'($urandom));
      end
      repeat (4) idle();

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end
endmodule
